// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX bypass network, load-use detection and long-latency scoreboard stalls
module fwd_hazard_unit #(
    parameter int NRD   = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*5-1:0]    rf_ra_ex,
    input  logic [NRD*5-1:0]    rf_ra_id,
    input  logic                rf_we_mem,
    input  logic                rf_we_wb,
    input  logic [4:0]          rf_wa_mem,
    input  logic [4:0]          rf_wa_wb,
    input  logic [XLEN-1:0]     rf_wd_mem,
    input  logic [XLEN-1:0]     rf_wd_wb,
    input  logic                ld_ex,
    input  logic [4:0]          rf_wa_ex,
    input  logic                lu_id,
    input  logic [4:0]          rf_wa_id,
    input  logic                lu_issue,
    input  logic                lu_done,
    input  logic [4:0]          lu_done_wa,
    output logic [NRD-1:0]      rf_rd_fe,
    output logic [NRD*XLEN-1:0] rf_rd_fd,
    output logic                stall_id,
    output logic                flush_ex,
    output logic                sb_full,
    output logic [31:0]         stall_cnt
);

    logic [DEPTH-1:0] sb_valid;
    logic [DEPTH-1:0] sb_valid_nx;
    logic [4:0]       sb_wa    [DEPTH];
    logic [4:0]       sb_wa_nx [DEPTH];
    logic             ret_done;
    logic             alloc_done;
    logic             load_use;
    logic             raw_hit;
    logic             waw_hit;
    logic [4:0]       ra;

    // MEM is the younger producer, so it is tested first
    always_comb begin
        rf_rd_fe = '0;
        rf_rd_fd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rf_we_mem && rf_wa_mem != 5'd0 && rf_wa_mem == rf_ra_ex[5*i +: 5]) begin
                rf_rd_fe[i]               = 1'b1;
                rf_rd_fd[XLEN*i +: XLEN]  = rf_wd_mem;
            end else if (rf_we_wb && rf_wa_wb != 5'd0 && rf_wa_wb == rf_ra_ex[5*i +: 5]) begin
                rf_rd_fe[i]               = 1'b1;
                rf_rd_fd[XLEN*i +: XLEN]  = rf_wd_wb;
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        raw_hit  = 1'b0;
        waw_hit  = 1'b0;
        ra       = 5'd0;
        for (int i = 0; i < NRD; i++) begin
            ra = rf_ra_id[5*i +: 5];
            if (ld_ex && rf_wa_ex != 5'd0 && ra == rf_wa_ex)
                load_use = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                if (sb_valid[j] && ra != 5'd0 && sb_wa[j] == ra)
                    raw_hit = 1'b1;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (lu_id && sb_valid[j] && sb_wa[j] == rf_wa_id)
                waw_hit = 1'b1;
        end
    end

    assign sb_full  = &sb_valid;
    assign stall_id = load_use | raw_hit | waw_hit | (lu_id & sb_full);
    assign flush_ex = stall_id;

    // Retire before allocate so a full scoreboard can reuse the slot freed this cycle
    always_comb begin
        sb_valid_nx = sb_valid;
        sb_wa_nx    = sb_wa;
        ret_done    = 1'b0;
        alloc_done  = 1'b0;
        if (lu_done) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (!ret_done && sb_valid[j] && sb_wa[j] == lu_done_wa) begin
                    sb_valid_nx[j] = 1'b0;
                    ret_done       = 1'b1;
                end
            end
        end
        if (lu_issue && rf_wa_ex != 5'd0) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (!alloc_done && !sb_valid_nx[j]) begin
                    sb_valid_nx[j] = 1'b1;
                    sb_wa_nx[j]    = rf_wa_ex;
                    alloc_done     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid  <= '0;
            stall_cnt <= 32'd0;
            for (int j = 0; j < DEPTH; j++)
                sb_wa[j] <= 5'd0;
        end else begin
            sb_valid <= sb_valid_nx;
            sb_wa    <= sb_wa_nx;
            if (stall_id)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Issuing into a full scoreboard means ID failed to honour its stall
    assert property (@(posedge clk) disable iff (rst)
        !(lu_issue && rf_wa_ex != 5'd0 && !alloc_done));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - randomized and directed checks of fwd_hazard_unit against a pending-register model
module tb_fwd_hazard_unit;
    localparam int NRD   = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*5-1:0]    rf_ra_ex, rf_ra_id;
    logic                rf_we_mem, rf_we_wb;
    logic [4:0]          rf_wa_mem, rf_wa_wb;
    logic [XLEN-1:0]     rf_wd_mem, rf_wd_wb;
    logic                ld_ex;
    logic [4:0]          rf_wa_ex;
    logic                lu_id;
    logic [4:0]          rf_wa_id;
    logic                lu_issue, lu_done;
    logic [4:0]          lu_done_wa;
    logic [NRD-1:0]      rf_rd_fe;
    logic [NRD*XLEN-1:0] rf_rd_fd;
    logic                stall_id, flush_ex, sb_full;
    logic [31:0]         stall_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pend[$];
    logic [31:0] m_cnt = 32'd0;

    fwd_hazard_unit #(.NRD(NRD), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rf_ra_ex(rf_ra_ex), .rf_ra_id(rf_ra_id),
        .rf_we_mem(rf_we_mem), .rf_we_wb(rf_we_wb),
        .rf_wa_mem(rf_wa_mem), .rf_wa_wb(rf_wa_wb),
        .rf_wd_mem(rf_wd_mem), .rf_wd_wb(rf_wd_wb),
        .ld_ex(ld_ex), .rf_wa_ex(rf_wa_ex),
        .lu_id(lu_id), .rf_wa_id(rf_wa_id),
        .lu_issue(lu_issue), .lu_done(lu_done), .lu_done_wa(lu_done_wa),
        .rf_rd_fe(rf_rd_fe), .rf_rd_fd(rf_rd_fd),
        .stall_id(stall_id), .flush_ex(flush_ex),
        .sb_full(sb_full), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic bit pending(input int r);
        foreach (pend[k]) if (pend[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        int a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rf_ra_id[5*i +: 5]);
            if (ld_ex && rf_wa_ex != 5'd0 && a == int'(rf_wa_ex)) s = 1'b1;
            if (a != 0 && pending(a)) s = 1'b1;
        end
        if (lu_id && (pending(int'(rf_wa_id)) || pend.size() == DEPTH)) s = 1'b1;
        return s;
    endfunction

    task automatic idle();
        rf_ra_ex = '0; rf_ra_id = '0;
        rf_we_mem = 0; rf_we_wb = 0; rf_wa_mem = 0; rf_wa_wb = 0;
        rf_wd_mem = 0; rf_wd_wb = 0;
        ld_ex = 0; rf_wa_ex = 0; lu_id = 0; rf_wa_id = 0;
        lu_issue = 0; lu_done = 0; lu_done_wa = 0;
    endtask

    task automatic check_outputs();
        logic            efe;
        logic [XLEN-1:0] efd;
        int              a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rf_ra_ex[5*i +: 5]);
            efe = 1'b0; efd = '0;
            if (rf_we_mem && rf_wa_mem != 0 && int'(rf_wa_mem) == a) begin efe = 1'b1; efd = rf_wd_mem; end
            else if (rf_we_wb && rf_wa_wb != 0 && int'(rf_wa_wb) == a) begin efe = 1'b1; efd = rf_wd_wb; end
            check($sformatf("fe%0d", i), rf_rd_fe[i], efe);
            check($sformatf("fd%0d", i), rf_rd_fd[XLEN*i +: XLEN], efd);
        end
        check("stall_id", stall_id, m_stall());
        check("flush_ex", flush_ex, m_stall());
        check("sb_full", sb_full, pend.size() == DEPTH);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    // Inputs are set just after a falling edge; outputs checked 1ns later, model advanced at the rising edge
    task automatic step();
        bit s;
        #1;
        check_outputs();
        s = m_stall();
        @(posedge clk);
        if (!rst) begin
            if (s) m_cnt++;
            if (lu_done) begin
                for (int k = 0; k < pend.size(); k++)
                    if (pend[k] == int'(lu_done_wa)) begin pend.delete(k); break; end
            end
            if (lu_issue && rf_wa_ex != 0 && pend.size() < DEPTH) pend.push_back(int'(rf_wa_ex));
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); lu_issue = 1; rf_wa_ex = r; step();
    endtask

    task automatic retire(input logic [4:0] r);
        idle(); lu_done = 1; lu_done_wa = r; step();
    endtask

    initial begin
        bit free;
        rst = 1'b1;
        idle();
        #1;
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_full", sb_full, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // forwarding priority
        idle();
        rf_we_mem = 1; rf_wa_mem = 5; rf_wd_mem = 32'h11;
        rf_we_wb = 1;  rf_wa_wb = 5;  rf_wd_wb = 32'h22;
        rf_ra_ex[4:0] = 5;
        #1 check("fwd_mem_wins", rf_rd_fd[31:0], 32'h11);
        step();
        rf_we_mem = 0;
        #1 check("fwd_wb", rf_rd_fd[31:0], 32'h22);
        step();
        rf_ra_ex[4:0] = 0; rf_wa_mem = 0; rf_wa_wb = 0; rf_we_mem = 1;
        #1 check("fwd_r0", rf_rd_fe[0], 1'b0);
        step();

        // load-use
        idle(); ld_ex = 1; rf_wa_ex = 7; rf_ra_id[9:5] = 7;
        #1 check("load_use", stall_id, 1'b1);
        step();
        idle();
        #1 check("load_use_cnt", stall_cnt, 32'd1);
        step();

        // RAW: r9 pending, retire at cycle 3, stall clears the cycle after
        issue(9);
        idle(); rf_ra_id[4:0] = 9; step(); step();
        lu_done = 1; lu_done_wa = 9;
        #1 check("raw_done_cycle", stall_id, 1'b1);
        step();
        idle(); rf_ra_id[4:0] = 9;
        #1 check("raw_cleared", stall_id, 1'b0);
        step();

        // full / structural, then retire+issue in one cycle
        for (int r = 1; r <= 4; r++) issue(5'(r));
        idle(); lu_id = 1; rf_wa_id = 20;
        #1 check("struct_stall", stall_id, 1'b1);
        step();
        idle(); lu_done = 1; lu_done_wa = 2; lu_issue = 1; rf_wa_ex = 6; step();
        idle();
        #1 check("full_after_swap", sb_full, 1'b1);
        rf_ra_id[4:0] = 2; step();
        rf_ra_id[4:0] = 6; step();
        for (int r = 1; r <= 6; r++) if (r != 2 && r != 5) retire(5'(r));

        // WAW
        issue(3);
        idle(); lu_id = 1; rf_wa_id = 3;
        #1 check("waw_stall", stall_id, 1'b1);
        step();
        lu_done = 1; lu_done_wa = 3; step();
        idle(); lu_id = 1; rf_wa_id = 3;
        #1 check("waw_cleared", stall_id, 1'b0);
        step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int i = 0; i < NRD; i++) begin
                rf_ra_ex[5*i +: 5] = 5'($urandom_range(0, 7));
                rf_ra_id[5*i +: 5] = 5'($urandom_range(0, 7));
            end
            rf_we_mem = 1'($urandom); rf_we_wb = 1'($urandom);
            rf_wa_mem = 5'($urandom_range(0, 7)); rf_wa_wb = 5'($urandom_range(0, 7));
            rf_wd_mem = $urandom; rf_wd_wb = $urandom;
            ld_ex = ($urandom_range(0, 3) == 0);
            rf_wa_ex = 5'($urandom_range(0, 7));
            lu_id = 1'($urandom); rf_wa_id = 5'($urandom_range(0, 7));
            lu_done = 1'($urandom);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                lu_done_wa = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                lu_done_wa = 5'($urandom_range(0, 7));
            free = lu_done && pending(int'(lu_done_wa));
            lu_issue = ($urandom_range(0, 2) == 0) && (pend.size() - int'(free) < DEPTH);
            step();
        end

        // asynchronous reset with 3 entries pending and stall_cnt at 17
        idle();
        rst = 1; #1; pend.delete(); m_cnt = 0;
        @(negedge clk); rst = 0;
        for (int r = 1; r <= 3; r++) issue(5'(r));
        while (m_cnt < 17) begin
            idle(); ld_ex = 1; rf_wa_ex = 7; rf_ra_id[4:0] = 7; step();
        end
        idle(); rf_ra_id[4:0] = 1;
        #1 check("pre_rst_cnt", stall_cnt, 32'd17);
        check("pre_rst_raw", stall_id, 1'b1);
        #2 rst = 1;
        #1;
        check("rst_async_full", sb_full, 1'b0);
        check("rst_async_cnt", stall_cnt, 32'd0);
        check("rst_async_raw", stall_id, 1'b0);
        pend.delete(); m_cnt = 0;
        @(negedge clk); rst = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline. It extends the EX-stage bypass network to NRD read ports. It also detects load-use hazards and tracks multi-cycle (MUL/DIV) writebacks in a DEPTH-entry scoreboard, issuing ID-stage stalls and EX bubbles. It sits between the ID/EX pipeline registers and the hazard-control path, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- NRD, 2, number of register read ports per instruction
- XLEN, 32, datapath width
- DEPTH, 4, max outstanding long-latency ops (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous and active-high
- rf_ra_ex  in  NRD*5  EX read addresses, port i at [5i+4:5i]
- rf_ra_id  in  NRD*5  ID read addresses, same packing
- rf_we_mem, rf_we_wb  in  1  write enables of MEM/WB
- rf_wa_mem, rf_wa_wb  in  5  write addresses of MEM/WB
- rf_wd_mem, rf_wd_wb  in  XLEN  write data of MEM/WB
- ld_ex  in  1  EX instruction is a load
- rf_wa_ex  in  5  EX destination
- lu_id  in  1  ID instruction is long-latency
- rf_wa_id  in  5  ID destination
- lu_issue  in  1  long-latency op leaves EX this cycle (dest = rf_wa_ex)
- lu_done  in  1  long-latency result written back this cycle
- lu_done_wa  in  5  destination of retiring op
- rf_rd_fe  out  NRD  forward enable per port
- rf_rd_fd  out  NRD*XLEN  forward data per port
- stall_id  out  1  hold PC and IF/ID, insert bubble
- flush_ex  out  1  load ID/EX with NOP (equals stall_id)
- sb_full  out  1  all DEPTH entries valid
- stall_cnt  out  32  cycles with stall_id=1

## Operation
- Forwarding, per port i, combinational:
  - If rf_we_mem, rf_wa_mem≠0 and rf_wa_mem==ra_ex[i]: fe=1, fd=rf_wd_mem.
  - Else the same test against WB: fe=1, fd=rf_wd_wb.
  - Else fe=0, fd=0.
  - MEM always beats WB. Address 0 never forwards.
- Load-use: stall when ld_ex, rf_wa_ex≠0 and any ra_id[i]==rf_wa_ex.
- Scoreboard: DEPTH entries {valid, wa}.
  - lu_issue with rf_wa_ex≠0 allocates the lowest-index free entry.
  - lu_done clears the lowest-index valid entry whose wa==lu_done_wa. A done with no match is ignored.
- Scoreboard stall (RAW): any ra_id[i]≠0 matches a valid entry.
- Scoreboard stall (WAW): lu_id and rf_wa_id matches a valid entry.
- Scoreboard stall (structural): lu_id and sb_full.
- stall_id = OR of all stall conditions.
- flush_ex = stall_id.
- stall_cnt increments by 1 per cycle with stall_id=1 and wraps at 2^32.

## Timing
- Forwarding and stall outputs are combinational from inputs and current scoreboard state. Zero-cycle latency.
- Scoreboard state and stall_cnt update on posedge clk.
- Reset, asynchronous, immediate:
  - all entries invalid
  - stall_cnt=0
  - sb_full=0
  - stall_id/flush_ex reflect load-use terms only
  - rf_rd_fe/fd depend on inputs only
- Simultaneous lu_issue and lu_done in one cycle:
  - Retire first, then allocate.
  - Issue while full with a matching done succeeds using the freed slot.
  - Same-register issue+done leaves that register pending (new entry).
- lu_issue while full with no done: dropped; violation of the ID stall contract. Assert-checked in simulation.
- lu_done retires at the clock edge. The same-cycle value reaches EX via WB forwarding. The ID RAW stall still sees the entry valid that cycle and drops next cycle, one extra stall cycle by design.
- rst mid-operation discards all pending entries. Upstream flushes the pipeline in the same reset.

## Test plan
- Forward priority: MEM writes r5=0x11, WB writes r5=0x22, ra_ex[0]=5 -> fe[0]=1, fd=0x11. With MEM we=0 -> fd=0x22. With ra=0 -> fe=0.
- Load-use: ld_ex=1, rf_wa_ex=7, ra_id[1]=7 -> stall_id=flush_ex=1 for that cycle. stall_cnt +1 next edge.
- RAW scoreboard: lu_issue for r9 at cycle 0. ra_id[0]=9 stalls cycles 1..N. lu_done(r9) at cycle N -> stall_id=0 at cycle N+1.
- Full/structural (DEPTH=4): issue r1..r4 -> sb_full=1. lu_id=1 -> stall_id=1. Then lu_done(r2)+lu_issue(r6) in the same cycle -> entries {r1,r6,r3,r4}, sb_full stays 1.
- WAW: r3 pending, lu_id=1, rf_wa_id=3 -> stall_id=1 until r3 retires.
- Async reset: assert rst mid-clock with 3 entries valid and stall_cnt=17 -> sb_full=0, stall_cnt=0, RAW stalls clear immediately without a clock edge.
